// File: rtl/scan_test_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : scan_test_ctrl_if
//  Description : Handshake/data bundle between a pattern source, the scan
//                test controller and the scan core configuration pins.
//                master : pattern source / system side (drives commands and
//                         per-shift data, observes status)
//                slave  : scan_test_ctrl itself
//                BIT_W must equal $clog2(CHAIN_LEN) of the attached
//                controller; the default matches a 211-flop chain.
//  Revision    : 1.0  initial release
// ============================================================================
interface scan_test_ctrl_if #(
   parameter int PAT_W = 16,
   parameter int CNT_W = 16,
   parameter int BIT_W = 8
);
   // commands and per-shift data from the source / core
   logic             START;
   logic             ABORT;
   logic [PAT_W-1:0] NUM_PAT;
   logic             SI_DATA;
   logic             EXP_DATA;
   logic             MASK_DATA;
   logic             SO;
   // scan control and results from the controller
   logic             TEST_MODE;
   logic             SE;
   logic             SI;
   logic             DATA_REQ;
   logic             CAP;
   logic             BUSY;
   logic             DONE;
   logic             FAIL;
   logic [CNT_W-1:0] FAIL_COUNT;
   logic [PAT_W-1:0] FAIL_PAT;
   logic [BIT_W-1:0] FAIL_BIT;

   modport master (
      output START, ABORT, NUM_PAT, SI_DATA, EXP_DATA, MASK_DATA, SO,
      input  TEST_MODE, SE, SI, DATA_REQ, CAP, BUSY, DONE, FAIL,
             FAIL_COUNT, FAIL_PAT, FAIL_BIT
   );

   modport slave (
      input  START, ABORT, NUM_PAT, SI_DATA, EXP_DATA, MASK_DATA, SO,
      output TEST_MODE, SE, SI, DATA_REQ, CAP, BUSY, DONE, FAIL,
             FAIL_COUNT, FAIL_PAT, FAIL_BIT
   );
endinterface
`default_nettype wire

// File: rtl/scan_test_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : scan_test_ctrl
//  Description : Full-scan test sequencer. Loads the first pattern, then
//                alternates capture and combined shift (load next / unload
//                previous response), finishing with a pure unload. Scan-out
//                is compared against expected data under a per-bit mask and
//                the first failing pattern/bit plus a saturating failure
//                count are recorded.
//  Ports       : CK   - rising-edge clock shared with the scan core
//                RST  - synchronous active-high reset
//                bus  - scan_test_ctrl_if.slave: START/ABORT/NUM_PAT command,
//                       SI_DATA/EXP_DATA/MASK_DATA source data, SO from core;
//                       TEST_MODE/SE/SI/DATA_REQ/CAP/BUSY/DONE control and
//                       FAIL/FAIL_COUNT/FAIL_PAT/FAIL_BIT results
//  Revision    : 1.0  initial release
// ============================================================================
module scan_test_ctrl #(
   parameter int CHAIN_LEN  = 211,
   parameter int CAP_CYCLES = 1,
   parameter int PAT_W      = 16,
   parameter int CNT_W      = 16
) (
   input logic             CK,
   input logic             RST,
   scan_test_ctrl_if.slave bus
);
   localparam int c_bit_w = $clog2(CHAIN_LEN);
   localparam int c_cc_w  = (CAP_CYCLES > 1) ? $clog2(CAP_CYCLES) : 1;
   localparam logic [c_bit_w-1:0] c_bc_last = c_bit_w'(CHAIN_LEN - 1);
   localparam logic [c_cc_w-1:0]  c_cc_last = c_cc_w'(CAP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_CAPTURE = 3'd2,
      S_SHIFT   = 3'd3,
      S_UNLOAD  = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   // Every control output is a pure function of the state; it is registered
   // together with the state so outputs are glitch-free and state-aligned.
   typedef struct packed {
      logic test_mode;
      logic se;
      logic si_en;
      logic data_req;
      logic cap;
      logic busy;
      logic done;
      logic cmp_en;
   } outs_t;

   function automatic outs_t decode(input state_t s);
      outs_t o;
      o = '0;
      case (s)
         S_LOAD:    begin o.test_mode = 1'b1; o.busy = 1'b1; o.se = 1'b1;
                          o.data_req = 1'b1; o.si_en = 1'b1; end
         S_CAPTURE: begin o.test_mode = 1'b1; o.busy = 1'b1; o.cap = 1'b1; end
         S_SHIFT:   begin o.test_mode = 1'b1; o.busy = 1'b1; o.se = 1'b1;
                          o.data_req = 1'b1; o.si_en = 1'b1; o.cmp_en = 1'b1; end
         // Unload keeps the source requested (EXP/MASK still needed) but
         // shifts zeros into the chain.
         S_UNLOAD:  begin o.test_mode = 1'b1; o.busy = 1'b1; o.se = 1'b1;
                          o.data_req = 1'b1; o.cmp_en = 1'b1; end
         S_DONE:    o.done = 1'b1;
         default:   o = '0;
      endcase
      return o;
   endfunction

   state_t             r_state;
   outs_t              r_outs;
   logic [c_bit_w-1:0] r_bc;
   logic [c_cc_w-1:0]  r_cc;
   logic [PAT_W-1:0]   r_pc;
   logic [PAT_W-1:0]   r_num_pat;
   logic               r_fail;
   logic [CNT_W-1:0]   r_fail_count;
   logic [PAT_W-1:0]   r_fail_pat;
   logic [c_bit_w-1:0] r_fail_bit;
   logic               w_mismatch;

   assign w_mismatch = r_outs.cmp_en & (bus.SO ^ bus.EXP_DATA) & ~bus.MASK_DATA;

   always_ff @(posedge CK) begin
      if (RST) begin
         r_state      <= S_IDLE;
         r_outs       <= '0;
         r_bc         <= '0;
         r_cc         <= '0;
         r_pc         <= '0;
         r_num_pat    <= '0;
         r_fail       <= 1'b0;
         r_fail_count <= '0;
         r_fail_pat   <= '0;
         r_fail_bit   <= '0;
      end else begin
         // Only the first mismatch of a run is located; later ones just count.
         if (w_mismatch) begin
            if (!r_fail) begin
               r_fail     <= 1'b1;
               r_fail_pat <= r_pc - 1'b1;
               r_fail_bit <= r_bc;
            end
            if (!(&r_fail_count))
               r_fail_count <= r_fail_count + 1'b1;
         end

         case (r_state)
            S_IDLE, S_DONE: begin
               if (bus.START) begin
                  r_num_pat    <= bus.NUM_PAT;
                  r_pc         <= '0;
                  r_bc         <= '0;
                  r_cc         <= '0;
                  r_fail       <= 1'b0;
                  r_fail_count <= '0;
                  r_fail_pat   <= '0;
                  r_fail_bit   <= '0;
                  if (bus.NUM_PAT == '0) begin
                     r_state <= S_DONE;
                     r_outs  <= decode(S_DONE);
                  end else begin
                     r_state <= S_LOAD;
                     r_outs  <= decode(S_LOAD);
                  end
               end
            end
            default: begin
               if (bus.ABORT) begin
                  r_state <= S_IDLE;
                  r_outs  <= decode(S_IDLE);
                  r_bc    <= '0;
                  r_cc    <= '0;
               end else begin
                  case (r_state)
                     S_LOAD, S_SHIFT: begin
                        if (r_bc == c_bc_last) begin
                           r_bc    <= '0;
                           r_state <= S_CAPTURE;
                           r_outs  <= decode(S_CAPTURE);
                        end else begin
                           r_bc <= r_bc + 1'b1;
                        end
                     end
                     S_CAPTURE: begin
                        if (r_cc == c_cc_last) begin
                           r_cc <= '0;
                           r_pc <= r_pc + 1'b1;
                           // r_pc+1 is the number of patterns now captured
                           if ((r_pc + 1'b1) < r_num_pat) begin
                              r_state <= S_SHIFT;
                              r_outs  <= decode(S_SHIFT);
                           end else begin
                              r_state <= S_UNLOAD;
                              r_outs  <= decode(S_UNLOAD);
                           end
                        end else begin
                           r_cc <= r_cc + 1'b1;
                        end
                     end
                     S_UNLOAD: begin
                        if (r_bc == c_bc_last) begin
                           r_bc    <= '0;
                           r_state <= S_DONE;
                           r_outs  <= decode(S_DONE);
                        end else begin
                           r_bc <= r_bc + 1'b1;
                        end
                     end
                     default: begin
                        r_state <= S_IDLE;
                        r_outs  <= decode(S_IDLE);
                     end
                  endcase
               end
            end
         endcase
      end
   end

   assign bus.TEST_MODE  = r_outs.test_mode;
   assign bus.SE         = r_outs.se;
   assign bus.SI         = r_outs.si_en & bus.SI_DATA;
   assign bus.DATA_REQ   = r_outs.data_req;
   assign bus.CAP        = r_outs.cap;
   assign bus.BUSY       = r_outs.busy;
   assign bus.DONE       = r_outs.done;
   assign bus.FAIL       = r_fail;
   assign bus.FAIL_COUNT = r_fail_count;
   assign bus.FAIL_PAT   = r_fail_pat;
   assign bus.FAIL_BIT   = r_fail_bit;
endmodule
`default_nettype wire

// File: tb/tb_scan_test_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scan_test_ctrl
//  Description : Bench for scan_test_ctrl with a 4-flop scan core whose
//                functional capture is an inverting rotate of its flops.
//                Random scan-in patterns; expected scan-out derived from the
//                pattern values, with selected bits flipped and/or masked.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_scan_test_ctrl;
   localparam int L     = 4;
   localparam int C     = 1;
   localparam int PAT_W = 16;
   localparam int CNT_W = 2;
   localparam int BIT_W = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic CK  = 1'b0;
   logic RST = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic [3:0] flip_v [8];
   logic [3:0] mask_v [8];

   scan_test_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .BIT_W(BIT_W)) bus ();

   scan_test_ctrl #(
      .CHAIN_LEN (L),
      .CAP_CYCLES(C),
      .PAT_W     (PAT_W),
      .CNT_W     (CNT_W)
   ) dut (
      .CK (CK),
      .RST(RST),
      .bus(bus)
   );

   always #5 CK = ~CK;

   // scan core: shift toward bit 3 when SE, functional capture when CAP
   logic [3:0] core_ff = 4'h0;
   always @(posedge CK) begin
      if (bus.SE)       core_ff <= {core_ff[2:0], bus.SI};
      else if (bus.CAP) core_ff <= {~core_ff[0], ~core_ff[3:1]};
   end
   assign bus.SO = core_ff[3];

   // response of the core to a loaded vector (shift k of a phase moves bit 3-k)
   function automatic logic [3:0] resp_of(input logic [3:0] v);
      return {~v[0], ~v[3:1]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ctl();
      return 32'({bus.SE, bus.CAP, bus.DATA_REQ, bus.BUSY, bus.TEST_MODE, bus.DONE});
   endfunction

   task automatic clear_vec();
      for (int i = 0; i < 8; i++) begin
         flip_v[i] = 4'h0;
         mask_v[i] = 4'h0;
      end
   endtask

   // stop_kind: 0 run to completion, 1 ABORT at cycle stop_t, 2 RST at stop_t
   task automatic run(input string name, input int n, input int stop_t, input int stop_kind,
                      input int glitch_t, input bit abort_with_start);
      logic [3:0] pat [8];
      int run_cnt = 0;
      int first_p = -1;
      int first_b = 0;
      int total   = n * (L + C) + L;
      bit stopped = 1'b0;
      for (int b = 0; b < n; b++) pat[b] = 4'($urandom_range(0, 15));

      bus.START = 1'b1; bus.NUM_PAT = 16'(n); bus.ABORT = abort_with_start;
      @(posedge CK); #1;
      bus.START = 1'b0; bus.ABORT = 1'b0; bus.NUM_PAT = 16'd9;

      for (int t = 1; t <= total; t++) begin
         int  blk  = (t - 1) / (L + C);
         int  off  = (t - 1) % (L + C);
         bit  shf  = (off < L);
         bit  cmp  = shf && (blk >= 1);
         bit  sin  = shf && (blk < n);
         logic exp_si;
         chk({name, "_ctl"}, ctl(), 32'({shf, !shf, shf, 1'b1, 1'b1, 1'b0}));
         exp_si = sin ? pat[blk][3-off] : 1'b0;
         bus.SI_DATA   = sin ? pat[blk][3-off] : 1'($urandom_range(0, 1));
         bus.EXP_DATA  = cmp ? (resp_of(pat[blk-1])[3-off] ^ flip_v[blk-1][off])
                             : 1'($urandom_range(0, 1));
         bus.MASK_DATA = cmp ? mask_v[blk-1][off] : 1'($urandom_range(0, 1));
         bus.START     = (t == glitch_t);
         if (t == stop_t && stop_kind == 1) bus.ABORT = 1'b1;
         if (t == stop_t && stop_kind == 2) RST = 1'b1;
         #1;
         chk({name, "_si"}, 32'(bus.SI), 32'(exp_si));
         @(posedge CK); #1;
         bus.START = 1'b0;
         bus.ABORT = 1'b0;
         if (cmp && flip_v[blk-1][off] && !mask_v[blk-1][off]) begin
            if (first_p < 0) begin first_p = blk - 1; first_b = off; end
            run_cnt++;
         end
         if (t == stop_t && stop_kind == 1) begin
            chk({name, "_abort_ctl"}, ctl(), 32'd0);
            chk({name, "_abort_fail"}, 32'(bus.FAIL), 32'(run_cnt > 0));
            chk({name, "_abort_cnt"}, 32'(bus.FAIL_COUNT), 32'(run_cnt > CNT_MAX ? CNT_MAX : run_cnt));
            stopped = 1'b1;
            break;
         end
         if (t == stop_t && stop_kind == 2) begin
            chk({name, "_rst_ctl"}, ctl(), 32'd0);
            chk({name, "_rst_cnt"}, 32'(bus.FAIL_COUNT), 32'd0);
            chk({name, "_rst_fail"}, 32'(bus.FAIL), 32'd0);
            @(posedge CK); #1;
            RST = 1'b0;
            @(posedge CK); #1;
            chk({name, "_rst_idle"}, ctl(), 32'd0);
            stopped = 1'b1;
            break;
         end
      end
      if (!stopped) begin
         chk({name, "_done_ctl"}, ctl(), 32'h01);
         chk({name, "_fail"}, 32'(bus.FAIL), 32'(run_cnt > 0));
         chk({name, "_cnt"}, 32'(bus.FAIL_COUNT), 32'(run_cnt > CNT_MAX ? CNT_MAX : run_cnt));
         chk({name, "_pat"}, 32'(bus.FAIL_PAT), 32'(first_p < 0 ? 0 : first_p));
         chk({name, "_bit"}, 32'(bus.FAIL_BIT), 32'(first_b));
      end
   endtask

   initial begin
      bus.START = 1'b0; bus.ABORT = 1'b0; bus.NUM_PAT = '0;
      bus.SI_DATA = 1'b0; bus.EXP_DATA = 1'b0; bus.MASK_DATA = 1'b0;
      clear_vec();

      // reset state
      RST = 1'b1;
      repeat (3) @(posedge CK);
      #1;
      chk("reset_ctl", ctl(), 32'd0);
      chk("reset_fail", 32'(bus.FAIL), 32'd0);
      chk("reset_cnt", 32'(bus.FAIL_COUNT), 32'd0);
      chk("reset_pat", 32'(bus.FAIL_PAT), 32'd0);
      chk("reset_bit", 32'(bus.FAIL_BIT), 32'd0);
      RST = 1'b0;
      @(posedge CK); #1;

      // ABORT while idle is ignored
      bus.ABORT = 1'b1;
      @(posedge CK); #1;
      bus.ABORT = 1'b0;
      chk("idle_abort_ctl", ctl(), 32'd0);

      // timing, clean run, START glitch while busy ignored
      clear_vec();
      run("timing", 2, 0, 0, 3, 1'b0);

      // injected faults (restart from DONE)
      clear_vec();
      flip_v[1][2] = 1'b1;
      flip_v[2][0] = 1'b1;
      run("fault", 3, 0, 0, 0, 1'b0);

      // zero patterns: DONE next cycle, SE never asserted
      bus.START = 1'b1; bus.NUM_PAT = '0;
      @(posedge CK); #1;
      bus.START = 1'b0;
      chk("zero_ctl", ctl(), 32'h01);
      chk("zero_fail", 32'(bus.FAIL), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge CK); #1;
         chk("zero_se", 32'(bus.SE), 32'd0);
      end

      // same faults, masked
      mask_v[1][2] = 1'b1;
      mask_v[2][0] = 1'b1;
      run("mask", 3, 0, 0, 0, 1'b0);

      // abort in 2nd SHIFT cycle keeps partial results
      clear_vec();
      flip_v[0][0] = 1'b1;
      run("abort", 2, L + C + 2, 1, 0, 1'b0);

      // re-start from IDLE with START and ABORT together: START wins
      clear_vec();
      run("restart", 2, 0, 0, 0, 1'b1);

      // saturating failure counter: 5 mismatches
      clear_vec();
      flip_v[0] = 4'b0011;
      flip_v[1] = 4'b1000;
      flip_v[2] = 4'b0110;
      run("sat", 3, 0, 0, 0, 1'b0);

      // reset asserted during SHIFT
      clear_vec();
      flip_v[0][0] = 1'b1;
      run("rst_shift", 2, L + C + 3, 2, 0, 1'b0);

      // random flips and masks
      clear_vec();
      for (int i = 0; i < 4; i++) begin
         flip_v[i] = 4'($urandom_range(0, 15));
         mask_v[i] = 4'($urandom_range(0, 15));
      end
      run("random", 4, 0, 0, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/scan_test_ctrl.md
Name: scan_test_ctrl

Overview:
- Sequences a full-scan test of a scan-inserted core, e.g. s9234_scan with a single 211-flop chain.
- Drives scan-enable and scan-in, and runs load / capture / unload cycles for a programmed number of patterns.
- Compares scan-out against expected data under a per-bit mask.
- Reports pass/fail, failure count and the first failing pattern/bit.
- Sits between a pattern source (ROM/LFSR/bench) and the scan core's config pins.

Parameters:
- CHAIN_LEN, 211, number of flops in the scan chain (≥2).
- CAP_CYCLES, 1, functional capture cycles per pattern (≥1).
- PAT_W, 16, width of pattern count/index.
- CNT_W, 16, width of failure counter.

Ports:
- CK  in  1  rising-edge clock, shared with scan core.
- RST  in  1  synchronous active-high reset.
- START  in  1  one-cycle pulse; accepted only in IDLE.
- ABORT  in  1  synchronous abort; returns to IDLE.
- NUM_PAT  in  PAT_W  pattern count, sampled on accepted START.
- SI_DATA  in  1  next scan-in bit from source.
- EXP_DATA  in  1  expected scan-out bit.
- MASK_DATA  in  1  1 = ignore this compare bit.
- SO  in  1  scan-out of core chain.
- TEST_MODE  out  1  high whenever not IDLE/DONE.
- SE  out  1  scan enable to core.
- SI  out  1  scan-in to core.
- DATA_REQ  out  1  source must present SI/EXP/MASK this cycle.
- CAP  out  1  capture cycle; PI source updates core inputs.
- BUSY  out  1  state ≠ IDLE and state ≠ DONE.
- DONE  out  1  run complete; held until next START or RST.
- FAIL  out  1  at least one unmasked mismatch this run.
- FAIL_COUNT  out  CNT_W  unmasked mismatches, saturating at all-ones.
- FAIL_PAT  out  PAT_W  0-based pattern index of first mismatch.
- FAIL_BIT  out  clog2(CHAIN_LEN)  shift index of first mismatch.

Behaviour:
- **States:** IDLE, LOAD, CAPTURE, SHIFT, UNLOAD, DONE. Registered state, bit counter `bc` (0..CHAIN_LEN-1), capture counter, pattern counter `pc`.
- **Reset:** RST → IDLE. All outputs 0, all counters 0, FAIL_* cleared. RST overrides START and ABORT.
- **IDLE/DONE + START:**
  - NUM_PAT=0 → DONE next cycle, FAIL=0.
  - Otherwise → LOAD; latch NUM_PAT; clear FAIL, FAIL_COUNT, FAIL_PAT, FAIL_BIT, `pc`, `bc`; DONE←0.
- **LOAD** (first pattern in):
  - SE=1, DATA_REQ=1, SI=SI_DATA combinationally.
  - No compare, because the chain holds no captured response yet.
  - Lasts CHAIN_LEN cycles, then CAPTURE.
- **CAPTURE:**
  - SE=0, CAP=1, DATA_REQ=0, SI=0.
  - Lasts CAP_CYCLES cycles.
  - Then `pc` increments. If `pc`+1 < NUM_PAT → SHIFT; else → UNLOAD.
- **SHIFT** (load next pattern while unloading previous response):
  - SE=1, DATA_REQ=1, SI=SI_DATA.
  - Compare enabled. Lasts CHAIN_LEN cycles, then CAPTURE.
- **UNLOAD:**
  - SE=1, DATA_REQ=1, SI forced 0 (SI_DATA ignored).
  - Compare enabled. Lasts CHAIN_LEN cycles, then DONE.
- **DONE:** DONE=1, SE=0, TEST_MODE=0. Results held.
- **Compare:**
  - mismatch = (SO ^ EXP_DATA) & ~MASK_DATA, evaluated in the same cycle as the shift; results register at that edge.
  - Response index = `pc`-1 during SHIFT/UNLOAD; bit index = `bc`.
  - First mismatch of a run: FAIL←1 and FAIL_PAT/FAIL_BIT latch. Later mismatches do not overwrite them.
  - FAIL_COUNT increments per mismatch and saturates (no wrap).
- **Timing:** total active cycles for N≥1 patterns = N·(CHAIN_LEN+CAP_CYCLES) + CHAIN_LEN. DONE rises the cycle after the last UNLOAD shift.
- **Flow control:** source is always ready; no stall. SE never drops mid-shift.
- **Ignored inputs:**
  - START while BUSY is ignored.
  - ABORT while IDLE/DONE is ignored.
- **ABORT while BUSY:**
  - → IDLE next cycle; SE=0.
  - FAIL/FAIL_COUNT keep partial values; DONE stays 0.
- **START and ABORT in the same cycle while IDLE:** START wins.
- **Counter wrap:** `bc` wraps to 0 at each phase end. `pc` never exceeds NUM_PAT.

Test Plan (bench uses CHAIN_LEN=4, CAP_CYCLES=1, 4-flop shift-register model with functional capture = D inputs):
- **Reset:** RST=1 for 2 cycles during SHIFT → next cycle SE=0, BUSY=0, DONE=0, FAIL_COUNT=0, state IDLE.
- **Timing:** START, NUM_PAT=2, EXP matches model → SE high 4 cycles, CAP 1, SE 4, CAP 1, SE 4. DONE rises 14 cycles after LOAD entry; FAIL=0, FAIL_COUNT=0.
- **Injected fault:** NUM_PAT=3 with EXP bit flipped at pattern 1, bit 2 and pattern 2, bit 0 → FAIL=1, FAIL_COUNT=2, FAIL_PAT=1, FAIL_BIT=2.
- **Masking:** same flips with MASK_DATA=1 on those bits → FAIL=0, FAIL_COUNT=0.
- **Zero patterns:** NUM_PAT=0 → DONE=1 next cycle, SE never asserted.
- **Abort / saturation:**
  - ABORT in 2nd SHIFT cycle → IDLE next cycle, DONE=0.
  - Re-START works normally.
  - With CNT_W=2 and 5 mismatches, FAIL_COUNT=3.
